// File: rtl/asrv32_uart.sv
// asrv32_uart: memory-mapped 8N1 UART with a TX FIFO and a single-byte RX holding register
module asrv32_uart #(
  parameter int          CLK_FREQ_MHZ  = 12,
  parameter int          BAUD_RATE     = 115200,
  parameter logic [31:0] BASE_ADDRESS  = 32'h8000_0050,
  parameter int          TX_FIFO_DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  input  logic        i_wr_en,
  input  logic [3:0]  i_wr_mask,
  input  logic        i_stb,
  output logic        o_ack,
  input  logic        i_uart_rx,
  output logic        o_uart_tx,
  output logic        o_rx_interrupt
);
  localparam int DIV = CLK_FREQ_MHZ * 1_000_000 / BAUD_RATE;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(TX_FIFO_DEPTH);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] DIV_HALF = CW'(DIV / 2 - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic hit_tx, hit_rx, hit_st, rd, wr;
  logic tx_full, tx_empty, tx_busy, push, pop;
  logic [7:0] fifo [TX_FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] fill;
  state_t tx_state, tx_state_d;
  logic [CW-1:0] tx_cnt, tx_cnt_d;
  logic [2:0] tx_bit, tx_bit_d;
  logic [7:0] tx_sh, tx_sh_d;
  logic tx_line, tx_line_d, tx_tick;
  logic [1:0] sync;
  logic rx_s, rx_prev, rx_tick, load, ferr;
  state_t rx_state, rx_state_d;
  logic [CW-1:0] rx_cnt, rx_cnt_d;
  logic [2:0] rx_bit, rx_bit_d;
  logic [7:0] rx_sh, rx_sh_d, rx_byte;
  logic rx_valid, overrun, frame_err;
  logic [31:0] status;
  logic unused_bits;
  assign unused_bits = ^{i_wdata[31:8], i_wr_mask[3:1]};
  assign hit_tx = i_addr == BASE_ADDRESS;
  assign hit_rx = i_addr == BASE_ADDRESS + 32'd4;
  assign hit_st = i_addr == BASE_ADDRESS + 32'd8;
  assign rd = i_stb & ~i_wr_en;
  assign wr = i_stb & i_wr_en;
  assign tx_full = fill == (AW + 1)'(TX_FIFO_DEPTH);
  assign tx_empty = fill == '0;
  assign tx_busy = tx_state != IDLE;
  assign push = wr & hit_tx & i_wr_mask[0] & (~tx_full | pop);
  assign status = {26'b0, frame_err, overrun, rx_valid, tx_busy, tx_empty, tx_full};
  assign o_uart_tx = tx_line;
  assign o_rx_interrupt = rx_valid;
  assign rx_s = sync[1];
  assign tx_tick = tx_cnt == DIV_LAST;
  assign rx_tick = rx_cnt == DIV_LAST;
  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge i_clk) begin
    if (push) fifo[wp] <= i_wdata[7:0];
  end
  // FIFO pointers and fill level; simultaneous push and pop leave the level unchanged
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wp <= '0;
      rp <= '0;
      fill <= '0;
    end else begin
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      fill <= fill + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  end
  // TX next state: start, 8 data bits LSB first and stop, each DIV cycles long
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d = (tx_state == IDLE || tx_tick) ? '0 : tx_cnt + CW'(1);
    tx_bit_d = tx_bit;
    tx_sh_d = tx_sh;
    tx_line_d = tx_line;
    pop = 1'b0;
    case (tx_state)
      IDLE: if (!tx_empty) begin
        pop = 1'b1;
        tx_sh_d = fifo[rp];
        tx_line_d = 1'b0;
        tx_state_d = START;
      end
      START: if (tx_tick) begin
        tx_state_d = DATA;
        tx_bit_d = '0;
        tx_line_d = tx_sh[0];
      end
      DATA: if (tx_tick) begin
        tx_state_d = tx_bit == 3'd7 ? STOP : DATA;
        tx_bit_d = tx_bit + 3'd1;
        tx_sh_d = tx_sh >> 1;
        tx_line_d = tx_bit == 3'd7 ? 1'b1 : tx_sh[1];
      end
      default: if (tx_tick) tx_state_d = IDLE;
    endcase
  end
  // TX state register; the line returns high immediately on reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_state <= IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
      tx_line <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt <= tx_cnt_d;
      tx_bit <= tx_bit_d;
      tx_sh <= tx_sh_d;
      tx_line <= tx_line_d;
    end
  end
  // Two-flop synchroniser plus delayed copy for falling-edge detection
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync <= {sync[0], i_uart_rx};
      rx_prev <= rx_s;
    end
  end
  // RX next state: confirm start at mid-bit, then sample every DIV cycles
  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d = rx_state == IDLE ? '0 : rx_cnt + CW'(1);
    rx_bit_d = rx_bit;
    rx_sh_d = rx_sh;
    load = 1'b0;
    ferr = 1'b0;
    case (rx_state)
      IDLE: if (rx_prev && !rx_s) rx_state_d = START;
      START: if (rx_cnt == DIV_HALF) begin
        rx_state_d = rx_s ? IDLE : DATA;
        rx_cnt_d = '0;
        rx_bit_d = '0;
      end
      DATA: if (rx_tick) begin
        rx_state_d = rx_bit == 3'd7 ? STOP : DATA;
        rx_cnt_d = '0;
        rx_bit_d = rx_bit + 3'd1;
        rx_sh_d = {rx_s, rx_sh[7:1]};
      end
      default: if (rx_tick) begin
        rx_state_d = IDLE;
        load = rx_s;
        ferr = ~rx_s;
      end
    endcase
  end
  // RX state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_state <= IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
    end else begin
      rx_state <= rx_state_d;
      rx_cnt <= rx_cnt_d;
      rx_bit <= rx_bit_d;
      rx_sh <= rx_sh_d;
    end
  end
  // RX holding register and sticky flags; a new byte beats a same-cycle read clear
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_byte <= '0;
      rx_valid <= 1'b0;
      overrun <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_byte <= load ? rx_sh : rx_byte;
      rx_valid <= load | (rx_valid & ~(rd & hit_rx));
      overrun <= (overrun & ~(wr & hit_st & i_wr_mask[0] & i_wdata[4])) | (load & rx_valid);
      frame_err <= (frame_err & ~(wr & hit_st & i_wr_mask[0] & i_wdata[5])) | ferr;
    end
  end
  // Bus response: ack one cycle after every strobe, read data captured on reads only
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ack <= 1'b0;
      o_rdata <= '0;
    end else begin
      o_ack <= i_stb;
      if (rd) o_rdata <= hit_rx ? {rx_valid, 23'b0, rx_byte} : hit_st ? status : '0;
    end
  end
endmodule

// File: tb/tb_asrv32_uart.sv
// tb_asrv32_uart: scoreboard bench for the UART bus interface, TX line and RX path
module tb_asrv32_uart;
  localparam logic [31:0] B = 32'h8000_0050;
  logic i_clk = 1'b0, i_rst = 1'b1;
  logic [31:0] i_addr = '0, i_wdata = '0, o_rdata;
  logic i_wr_en = 1'b0, i_stb = 1'b0, o_ack, i_uart_rx = 1'b1, o_uart_tx, o_rx_interrupt;
  logic [3:0] i_wr_mask = '0;
  asrv32_uart #(.CLK_FREQ_MHZ(12), .BAUD_RATE(1_000_000), .BASE_ADDRESS(B), .TX_FIFO_DEPTH(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata),
    .i_wr_en(i_wr_en), .i_wr_mask(i_wr_mask), .i_stb(i_stb), .o_ack(o_ack),
    .i_uart_rx(i_uart_rx), .o_uart_tx(o_uart_tx), .o_rx_interrupt(o_rx_interrupt));
  always #5 i_clk = ~i_clk;
  typedef struct {logic rd; logic [31:0] data; string name;} exp_t;
  exp_t sb[$];
  exp_t e_mon;
  logic [7:0] tx_exp[$];
  logic [7:0] mon_b, mon_x;
  bit mon_en = 1'b1;
  logic stb_d;
  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask
  always @(posedge i_clk or posedge i_rst) stb_d <= i_rst ? 1'b0 : i_stb;
  // bus monitor: every strobe must be acked next cycle; reads are checked against the queue
  always @(negedge i_clk) begin
    if (!i_rst && (o_ack || stb_d)) begin
      chk("ack", {31'b0, o_ack}, {31'b0, stb_d});
      if (stb_d && sb.size() > 0) begin
        e_mon = sb.pop_front();
        if (e_mon.rd) chk(e_mon.name, o_rdata, e_mon.data);
      end
    end
  end
  // line monitor: decode each TX frame at mid-bit and compare with the expected byte queue
  initial forever begin
    @(negedge i_clk);
    if (mon_en && !i_rst && o_uart_tx === 1'b0) begin
      mon_x = tx_exp.size() > 0 ? tx_exp.pop_front() : 8'hxx;
      repeat (6) @(negedge i_clk);
      chk("tx_start_bit", {31'b0, o_uart_tx}, 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (12) @(negedge i_clk);
        mon_b[i] = o_uart_tx;
      end
      repeat (12) @(negedge i_clk);
      chk("tx_stop_bit", {31'b0, o_uart_tx}, 32'd1);
      chk("tx_byte", {24'b0, mon_b}, {24'b0, mon_x});
    end
  end
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] m,
                       input logic [31:0] exp, input string nm);
    @(posedge i_clk);
    #1;
    i_addr = a;
    i_wdata = d;
    i_wr_en = w;
    i_wr_mask = m;
    i_stb = 1'b1;
    sb.push_back('{!w, exp, nm});
  endtask
  task automatic idle();
    @(posedge i_clk);
    #1;
    i_stb = 1'b0;
    i_wr_en = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    issue(a, 32'd0, 1'b0, 4'h0, exp, nm);
    idle();
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    issue(a, d, 1'b1, m, 32'd0, "wr");
    idle();
  endtask
  task automatic rx_bit(input logic v);
    i_uart_rx = v;
    repeat (12) @(posedge i_clk);
    #1;
  endtask
  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(b[i]);
    rx_bit(stop);
    i_uart_rx = 1'b1;
  endtask
  task automatic wait_drain();
    for (int i = 0; i < 3000 && tx_exp.size() > 0; i++) @(negedge i_clk);
    chk("tx_drain", tx_exp.size(), 32'd0);
    repeat (140) @(negedge i_clk);
  endtask
  int n;
  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_ack", {31'b0, o_ack}, 32'd0);
    chk("rst_rdata", o_rdata, 32'd0);
    chk("rst_tx", {31'b0, o_uart_tx}, 32'd1);
    chk("rst_irq", {31'b0, o_rx_interrupt}, 32'd0);
    i_rst = 1'b0;
    rd(B + 32'h8, 32'h2, "status_reset");
    rd(B + 32'hC, 32'h0, "unmapped_rd");
    wr(B + 32'hC, 32'hFFFF_FFFF, 4'hF);
    rd(B, 32'h0, "txdata_rd");
    wr(B + 32'h4, 32'h55, 4'hF);
    wr(B + 32'h8, 32'hFF, 4'hF);
    rd(B + 32'h4, 32'h0, "rxdata_idle");
    rd(B + 32'h8, 32'h2, "status_ro_bits");
    // single byte 0xA5 with exact start-bit length
    tx_exp.push_back(8'hA5);
    wr(B, 32'hA5, 4'h1);
    for (int i = 0; i < 20 && o_uart_tx !== 1'b0; i++) @(negedge i_clk);
    n = 0;
    for (int i = 0; i < 40 && o_uart_tx === 1'b0; i++) begin
      n++;
      @(negedge i_clk);
    end
    chk("tx_start_len", n, 32'd12);
    rd(B + 32'h8, 32'h6, "status_busy");
    wait_drain();
    rd(B + 32'h8, 32'h2, "status_tx_done");
    // ten back-to-back writes: nine accepted, the tenth hits a full FIFO
    for (int i = 0; i < 10; i++) begin
      if (i < 9) tx_exp.push_back(8'h30 + 8'(i));
      issue(B, 32'h30 + i, 1'b1, 4'h1, 32'd0, "wr");
    end
    issue(B + 32'h8, 32'd0, 1'b0, 4'h0, 32'h5, "status_full");
    idle();
    wait_drain();
    rd(B + 32'h8, 32'h2, "status_after_burst");
    // RX byte, read-to-clear
    send_rx(8'h3C, 1'b1);
    repeat (5) @(negedge i_clk);
    chk("irq_set", {31'b0, o_rx_interrupt}, 32'd1);
    rd(B + 32'h4, 32'h8000_003C, "rx_first");
    rd(B + 32'h4, 32'h0000_003C, "rx_second");
    @(negedge i_clk);
    chk("irq_clr", {31'b0, o_rx_interrupt}, 32'd0);
    // overrun
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    repeat (5) @(negedge i_clk);
    rd(B + 32'h8, 32'h1A, "status_overrun");
    rd(B + 32'h4, 32'h8000_0022, "rx_overwrite");
    wr(B + 32'h8, 32'h10, 4'h1);
    rd(B + 32'h8, 32'h2, "status_ov_clr");
    // framing error, then a short glitch
    send_rx(8'h55, 1'b0);
    repeat (5) @(negedge i_clk);
    rd(B + 32'h8, 32'h22, "status_ferr");
    chk("irq_ferr", {31'b0, o_rx_interrupt}, 32'd0);
    wr(B + 32'h8, 32'h20, 4'h1);
    rd(B + 32'h8, 32'h2, "status_ferr_clr");
    @(posedge i_clk);
    #1;
    i_uart_rx = 1'b0;
    repeat (4) @(posedge i_clk);
    #1;
    i_uart_rx = 1'b1;
    repeat (30) @(negedge i_clk);
    rd(B + 32'h8, 32'h2, "status_glitch");
    rd(B + 32'h4, 32'h22, "rx_after_glitch");
    // reset in the middle of a TX frame
    mon_en = 1'b0;
    wr(B, 32'h5A, 4'h1);
    repeat (20) @(negedge i_clk);
    chk("tx_pre_rst", {31'b0, o_uart_tx}, 32'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    #1;
    chk("tx_in_rst", {31'b0, o_uart_tx}, 32'd1);
    chk("ack_in_rst", {31'b0, o_ack}, 32'd0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    rd(B + 32'h8, 32'h2, "status_after_rst");
    rd(B + 32'h4, 32'h0, "rx_after_rst");
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge i_clk);
      if (o_uart_tx !== 1'b1) n++;
    end
    chk("tx_idle_after_rst", n, 32'd0);
    mon_en = 1'b1;
    repeat (5) @(negedge i_clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
